// File: rtl/risc_dmem_pkg.sv
// rtl/risc_dmem_pkg.sv - shared state encoding and default sizing for the data-memory responder
package risc_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_DEFAULT       = 16;
    localparam int WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/risc_dmem_responder.sv
// rtl/risc_dmem_responder.sv - wait-state data memory with valid/ready request and response channels
module risc_dmem_responder
    import risc_dmem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        do_access;
    logic        accept;

    logic        we_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    logic        acc_we;
    logic [7:0]  acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_in_range;
    logic        dbg_in_range;

    logic [7:0]  mem [DEPTH];

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    cnt_d     = 4'd0;
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_in_range = {1'b0, acc_addr} < DEPTH9;
    assign dbg_in_range = {1'b0, dbg_addr} < DEPTH9;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (do_access) begin
                if (!acc_in_range) begin
                    rdata_q <= 8'd0;
                    err_q   <= 1'b1;
                end else if (acc_we) begin
                    mem[acc_addr[AW-1:0]] <= acc_wdata;
                    rdata_q               <= 8'd0;
                    err_q                 <= 1'b0;
                end else begin
                    rdata_q <= mem[acc_addr[AW-1:0]];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (state == RESP) ? rdata_q : 8'd0;
    assign rsp_err   = (state == RESP) ? err_q : 1'b0;
    assign dbg_data  = dbg_in_range ? mem[dbg_addr[AW-1:0]] : 8'd0;

endmodule

// File: tb/tb_risc_dmem_responder.sv
// tb/tb_risc_dmem_responder.sv - directed self-checking bench for risc_dmem_responder
module tb_risc_dmem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] dbg_addr = 8'd0;
    logic [7:0] dbg_data;

    logic       z_req_valid = 1'b0;
    logic       z_req_ready;
    logic       z_req_we = 1'b0;
    logic [7:0] z_req_addr = 8'd0;
    logic [7:0] z_req_wdata = 8'd0;
    logic       z_rsp_valid;
    logic       z_rsp_ready = 1'b0;
    logic [7:0] z_rsp_rdata;
    logic       z_rsp_err;
    logic [7:0] z_dbg_addr = 8'd0;
    logic [7:0] z_dbg_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_mem [16];

    always #5 clk = ~clk;

    risc_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    risc_dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
    );

    // lat counts falling-edge samples after the accept edge up to and including the first rsp_valid.
    task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       output int lat, output logic [7:0] rd, output logic er);
        int g;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic z_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output int lat, output logic [7:0] rd, output logic er);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!z_rsp_valid && lat < 20);
        rd = z_rsp_rdata;
        er = z_rsp_err;
        z_rsp_ready = 1'b1;
        @(posedge clk);
        #1 z_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, required 1 0 00 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        n_checks++;
        if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs_w0: ready=%b valid=%b, required 1 0", z_req_ready, z_rsp_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = 8'd0;
            dbg_addr = 8'(i);
            #1;
            n_checks++;
            if (dbg_data !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_mem[%0d]: got %h, required 00", i, dbg_data);
            end
        end
    endtask

    task automatic test_store_load;
        int lat; logic [7:0] rd; logic er;
        txn(1'b1, 8'd12, 8'd15, lat, rd, er);
        exp_mem[12] = 8'd15;
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d, required 3", lat); end
        n_checks++;
        if (rd !== 8'd0 || er !== 1'b0) begin
            n_fail++; $display("FAIL store_rsp: rdata=%h err=%b, required 00 0", rd, er);
        end
        dbg_addr = 8'd12;
        #1;
        n_checks++;
        if (dbg_data !== 8'd15) begin n_fail++; $display("FAIL dbg_after_store: got %h, required 0f", dbg_data); end
        txn(1'b0, 8'd12, 8'd0, lat, rd, er);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d, required 3", lat); end
        n_checks++;
        if (rd !== 8'd15 || er !== 1'b0) begin
            n_fail++; $display("FAIL load_rsp: rdata=%h err=%b, required 0f 0", rd, er);
        end
    endtask

    task automatic test_zero_wait;
        int lat; logic [7:0] rd; logic er;
        z_txn(1'b1, 8'd4, 8'h5A, lat, rd, er);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL w0_store_latency: got %0d, required 1", lat); end
        z_txn(1'b0, 8'd4, 8'd0, lat, rd, er);
        n_checks++;
        if (lat !== 1 || rd !== 8'h5A || er !== 1'b0) begin
            n_fail++;
            $display("FAIL w0_load: lat=%0d rdata=%h err=%b, required 1 5a 0", lat, rd, er);
        end
    endtask

    task automatic test_hold;
        int lat; logic [7:0] rd; logic er;
        int g;
        txn(1'b1, 8'd7, 8'h3C, lat, rd, er);
        exp_mem[7] = 8'h3C;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!rsp_valid && g < 20);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 3c 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'd0) begin
            n_fail++;
            $display("FAIL hold_release: ready=%b valid=%b rdata=%h, required 1 0 00",
                     req_ready, rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_out_of_range;
        int lat; logic [7:0] rd; logic er;
        txn(1'b1, 8'd20, 8'h77, lat, rd, er);
        n_checks++;
        if (lat !== 3 || rd !== 8'd0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_store: lat=%0d rdata=%h err=%b, required 3 00 1", lat, rd, er);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 8'(i);
            #1;
            n_checks++;
            if (dbg_data !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL oor_mem[%0d]: got %h, required %h", i, dbg_data, exp_mem[i]);
            end
        end
        dbg_addr = 8'd20;
        #1;
        n_checks++;
        if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL dbg_oor: got %h, required 00", dbg_data); end
    endtask

    task automatic test_reset_busy;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 8'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_ready: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'd0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_busy_rsp: %0d valid cycles, required 0", seen); end
        dbg_addr = 8'd3;
        #1;
        n_checks++;
        if (dbg_data !== 8'd0) begin n_fail++; $display("FAIL reset_busy_mem3: got %h, required 00", dbg_data); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [7:0] rd; logic er;
        int early;
        txn(1'b1, 8'd1, 8'h11, lat, rd, er);
        txn(1'b1, 8'd2, 8'h22, lat, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd1;
        @(posedge clk);
        #1 req_addr = 8'd2;
        early = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready) early++;
        end while (!rsp_valid && lat < 20);
        n_checks++;
        if (lat !== 3 || rsp_rdata !== 8'h11 || early !== 0) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d rdata=%h ready_cycles=%0d, required 3 11 0", lat, rsp_rdata, early);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle_after_handshake: ready=%b, required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        n_checks++;
        if (lat !== 3 || rsp_rdata !== 8'h22 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d rdata=%h err=%b, required 3 22 0", lat, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_zero_wait;
        test_hold;
        test_out_of_range;
        test_reset_busy;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
